// File: rtl/pe_reg_file_pkg.sv
// Shared PE package: instance sizing constants and activation direction codes
// used by the PE activation wrapper around its two ping-pong register files.
package pe_reg_file_pkg;

    // Default operand width and entry count of one PE register file.
    localparam int PE_DATA_WIDTH      = 16;
    localparam int PE_ACT_NO          = 16;
    localparam int PE_ACT_ADDR_WIDTH  = $clog2(PE_ACT_NO);

    // Which of the two register files currently acts as the input store.
    typedef enum logic {
        ACT_DIR_0 = 1'b0,
        ACT_DIR_1 = 1'b1
    } act_dir_e;

endpackage

// File: rtl/pe_reg_file_if.sv
// Access bus of one PE register file: write port, registered read port,
// bulk clear and the per-entry zero-flag vector.
interface pe_reg_file_if
    import pe_reg_file_pkg::*;
#(
    parameter int BIT_WIDTH = PE_DATA_WIDTH,
    parameter int REG_DEPTH = PE_ACT_NO
);
    localparam int ADDR_WIDTH = $clog2(REG_DEPTH);

    logic                  clear;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [BIT_WIDTH-1:0]  read_data;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [BIT_WIDTH-1:0]  write_data;
    logic [REG_DEPTH-1:0]  zeros;

    // Client side: issues reads, writes and clears.
    modport master (
        output clear, read_en, read_addr, write_en, write_addr, write_data,
        input  read_data, zeros
    );

    // Register file side.
    modport slave (
        input  clear, read_en, read_addr, write_en, write_addr, write_data,
        output read_data, zeros
    );
endinterface

// File: rtl/pe_reg_file.sv
// Flat per-PE operand register file: one synchronous write port, one
// registered read port, bulk synchronous clear and a combinational
// zero-flag per entry.
// Optional macro PE_REGFILE_BYPASS_EN: forwards same-address write data to
// the read port (write-first); otherwise reads return the old contents.
module pe_reg_file
    import pe_reg_file_pkg::*;
#(
    parameter int BIT_WIDTH = PE_DATA_WIDTH,
    parameter int REG_DEPTH = PE_ACT_NO
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_reg_file_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(REG_DEPTH);
    // Depth as an address-sized-plus-one value so range checks stay width-clean
    // for depths that are not powers of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = REG_DEPTH[ADDR_WIDTH:0];

    logic [BIT_WIDTH-1:0] mem_reg [REG_DEPTH];
    logic [BIT_WIDTH-1:0] read_data_reg;
    logic [BIT_WIDTH-1:0] read_data_next;
    logic                 write_in_range;
    logic                 read_in_range;

    assign write_in_range = ({1'b0, bus.write_addr} < DEPTH_L);
    assign read_in_range  = ({1'b0, bus.read_addr}  < DEPTH_L);

    // Storage update: clear wins over a same-cycle write; out-of-range writes drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.write_en && write_in_range) begin
            mem_reg[bus.write_addr] <= bus.write_data;
        end
    end

    // Next read value: holds when idle, zero outside the array, old contents
    // (or forwarded write data) on a same-address collision.
    always_comb begin
        read_data_next = read_data_reg;
        if (bus.read_en) begin
            if (read_in_range) begin
                read_data_next = mem_reg[bus.read_addr];
`ifdef PE_REGFILE_BYPASS_EN
                if (bus.write_en && !bus.clear && (bus.write_addr == bus.read_addr)) begin
                    read_data_next = bus.write_data;
                end
`endif
            end else begin
                read_data_next = '0;
            end
        end
    end

    // Read data register; clear leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_reg <= '0;
        end else begin
            read_data_reg <= read_data_next;
        end
    end

    assign bus.read_data = read_data_reg;

    // Zero detect straight from storage, so flags track the post-edge state.
    generate
        for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_zero
            assign bus.zeros[gi] = (mem_reg[gi] == '0);
        end
    endgenerate

endmodule

// File: tb/tb_pe_reg_file.sv
// Directed testbench for pe_reg_file (default 16 x 16 configuration).
module tb_pe_reg_file;
    import pe_reg_file_pkg::*;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    pe_reg_file_if bus ();

    pe_reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
        bus.write_en   = 1'b1;
        bus.write_addr = addr;
        bus.write_data = data;
        tick();
        bus.write_en   = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr);
        bus.read_en   = 1'b1;
        bus.read_addr = addr;
        tick();
        bus.read_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (bus.read_data !== 16'h0000 || bus.zeros !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL reset_state: read_data=%h zeros=%h required 0000/ffff", bus.read_data, bus.zeros);
        end
        rst_n = 1'b1;
        tick();
        do_write(4'd3, 16'h1234);
        vec_cnt++;
        if (bus.zeros !== 16'hFFF7) begin
            err_cnt++;
            $display("FAIL reset_prewrite_zeros: zeros=%h required fff7", bus.zeros);
        end
        do_read(4'd3);
        vec_cnt++;
        if (bus.read_data !== 16'h1234) begin
            err_cnt++;
            $display("FAIL reset_preread: read_data=%h required 1234", bus.read_data);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.read_data !== 16'h0000 || bus.zeros !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL async_reset: read_data=%h zeros=%h required 0000/ffff", bus.read_data, bus.zeros);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_read(4'd3);
        vec_cnt++;
        if (bus.read_data !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_readback: read_data=%h required 0000", bus.read_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        do_write(4'd5, 16'h00A5);
        vec_cnt++;
        if (bus.zeros !== 16'hFFDF) begin
            err_cnt++;
            $display("FAIL wr_zeros: zeros=%h required ffdf", bus.zeros);
        end
        do_read(4'd5);
        vec_cnt++;
        if (bus.read_data !== 16'h00A5) begin
            err_cnt++;
            $display("FAIL wr_read: read_data=%h required 00a5", bus.read_data);
        end
        bus.read_addr = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (bus.read_data !== 16'h00A5) begin
                err_cnt++;
                $display("FAIL wr_hold%0d: read_data=%h required 00a5", i, bus.read_data);
            end
        end
        $display("test_write_read done");
    endtask

    task automatic test_read_during_write();
        logic [15:0] exp_rd;
`ifdef PE_REGFILE_BYPASS_EN
        exp_rd = 16'h0022;
`else
        exp_rd = 16'h0011;
`endif
        do_write(4'd2, 16'h0011);
        bus.write_en   = 1'b1;
        bus.write_addr = 4'd2;
        bus.write_data = 16'h0022;
        bus.read_en    = 1'b1;
        bus.read_addr  = 4'd2;
        tick();
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        vec_cnt++;
        if (bus.read_data !== exp_rd) begin
            err_cnt++;
            $display("FAIL rdw_collision: read_data=%h required %h", bus.read_data, exp_rd);
        end
        do_read(4'd2);
        vec_cnt++;
        if (bus.read_data !== 16'h0022) begin
            err_cnt++;
            $display("FAIL rdw_after: read_data=%h required 0022", bus.read_data);
        end
        $display("test_read_during_write done");
    endtask

    task automatic test_zero_flag();
        do_write(4'd15, 16'hFFFF);
        vec_cnt++;
        if (bus.zeros !== 16'h7FDB) begin
            err_cnt++;
            $display("FAIL zf_negative: zeros=%h required 7fdb", bus.zeros);
        end
        do_write(4'd15, 16'h0000);
        vec_cnt++;
        if (bus.zeros !== 16'hFFDB) begin
            err_cnt++;
            $display("FAIL zf_zero: zeros=%h required ffdb", bus.zeros);
        end
        $display("test_zero_flag done");
    endtask

    task automatic test_clear_priority();
        do_write(4'd0, 16'h7FFF);
        // Same cycle: clear, a competing write, and a read of the pre-clear value.
        bus.clear      = 1'b1;
        bus.write_en   = 1'b1;
        bus.write_addr = 4'd1;
        bus.write_data = 16'h0001;
        bus.read_en    = 1'b1;
        bus.read_addr  = 4'd0;
        tick();
        bus.clear    = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        vec_cnt++;
        if (bus.zeros !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL clr_zeros: zeros=%h required ffff", bus.zeros);
        end
        vec_cnt++;
        if (bus.read_data !== 16'h7FFF) begin
            err_cnt++;
            $display("FAIL clr_read_preclear: read_data=%h required 7fff", bus.read_data);
        end
        do_read(4'd1);
        vec_cnt++;
        if (bus.read_data !== 16'h0000) begin
            err_cnt++;
            $display("FAIL clr_dropped_write: read_data=%h required 0000", bus.read_data);
        end
        $display("test_clear_priority done");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 16'(i + 1));
        end
        vec_cnt++;
        if (bus.zeros !== 16'h0000) begin
            err_cnt++;
            $display("FAIL sweep_zeros: zeros=%h required 0000", bus.zeros);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i));
            vec_cnt++;
            if (bus.read_data !== 16'(i + 1)) begin
                err_cnt++;
                $display("FAIL sweep_read%0d: read_data=%h required %h", i, bus.read_data, 16'(i + 1));
            end
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        vec_cnt++;
        if (bus.zeros !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL sweep_clear_zeros: zeros=%h required ffff", bus.zeros);
        end
        do_read(4'd7);
        vec_cnt++;
        if (bus.read_data !== 16'h0000) begin
            err_cnt++;
            $display("FAIL sweep_clear_read: read_data=%h required 0000", bus.read_data);
        end
        $display("test_sweep done");
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        rst_n          = 1'b0;
        bus.clear      = 1'b0;
        bus.read_en    = 1'b0;
        bus.read_addr  = '0;
        bus.write_en   = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_zero_flag();
        test_clear_priority();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
